// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receive channel.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE2 = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    STOP2   = 3'd5,
    WAIT_HI = 3'd6
  } rx_state_e;

  localparam int ERR_W   = 3;
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ones_odd is the XOR of payload and received parity bit
  function automatic logic parity_fail(input logic ones_odd, input parity_e mode);
    logic fail;
    case (mode)
      PAR_EVEN: fail = ones_odd;
      PAR_ODD:  fail = ~ones_odd;
      default:  fail = 1'b0;
    endcase
    return fail;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO holding received entries; push while full drops
// the entry unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign level     = wr_ptr_r - rd_ptr_r;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (level == (AW+1)'(DEPTH));
  assign do_pop_s  = rd_en && !empty;
  assign do_push_s = wr_en && (!full || do_pop_s);
  assign overflow  = wr_en && full && !do_pop_s;
  assign rd_data   = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // Pointers carry one extra bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array; reads are masked while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receive channel: synchroniser, oversample tick generator, 3-sample
// majority voter and frame FSM feeding an error-tagged receive FIFO.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BRD_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  input  logic                        rx_en,
  input  logic [BRD_W-1:0]            brd,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic                        rd_en,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic [ERR_W-1:0]            rd_err,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        busy
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int ENT_W = DATA_BITS + ERR_W;
  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [BRD_W-1:0] BRD_ONE  = BRD_W'(1);

  rx_state_e            state_r, state_n;
  parity_e              parity_r;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic [BRD_W-1:0]     brd_eff_s, brd_r, tick_cnt_r;
  logic [CNT_W-1:0]     samp_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 two_stop_r, pbit_r, stop1_r, samp_a_r, samp_b_r;
  logic                 tick_s, mid_s, vote_s, start_s, par_en_s, push_s, overflow_s;
  logic                 stop1_s, overrun_r;
  logic [ERR_W-1:0]     err_s;
  logic [ENT_W-1:0]     head_s;

  assign brd_eff_s = (brd == '0) ? BRD_ONE : brd;
  assign tick_s    = (state_r != IDLE) && (tick_cnt_r == '0);
  assign mid_s     = tick_s && (samp_cnt_r == SMP_C);
  assign vote_s    = maj3(samp_a_r, samp_b_r, rx_sync_r);
  assign start_s   = (state_r == IDLE) && rx_en && rx_prev_r && !rx_sync_r;
  assign par_en_s  = (parity_r == PAR_EVEN) || (parity_r == PAR_ODD);

  // Error tags are only meaningful in the cycle the entry is pushed
  assign stop1_s        = (state_r == STOP) ? vote_s : stop1_r;
  assign err_s[ERR_PAR] = parity_fail(^data_r ^ pbit_r, parity_r);
  assign err_s[ERR_FRM] = !stop1_s || ((state_r == STOP2) && !vote_s);
  assign err_s[ERR_BRK] = (data_r == '0) && !(par_en_s && pbit_r) && !stop1_s;

  assign busy    = (state_r != IDLE);
  assign overrun = overrun_r;
  assign rd_data = head_s[DATA_BITS-1:0];
  assign rd_err  = head_s[ENT_W-1:DATA_BITS];

  // Two-flop synchroniser plus a history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_n;
  end

  // Next-state and push decision
  always_comb begin
    state_n = state_r;
    push_s  = 1'b0;
    if (!rx_en) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_n = start_s ? START : IDLE;
        START:   state_n = mid_s ? (vote_s ? IDLE : DATA) : START;
        DATA: begin
          if (mid_s && (bit_cnt_r == LAST_BIT)) state_n = par_en_s ? PARITY : STOP;
          else                                  state_n = DATA;
        end
        PARITY:  state_n = mid_s ? STOP : PARITY;
        STOP: begin
          if (mid_s && two_stop_r) begin
            state_n = STOP2;
          end else if (mid_s) begin
            push_s  = 1'b1;
            state_n = rx_sync_r ? IDLE : WAIT_HI;
          end else begin
            state_n = STOP;
          end
        end
        STOP2: begin
          if (mid_s) begin
            push_s  = 1'b1;
            state_n = rx_sync_r ? IDLE : WAIT_HI;
          end else begin
            state_n = STOP2;
          end
        end
        WAIT_HI: state_n = rx_sync_r ? IDLE : WAIT_HI;
        default: state_n = IDLE;
      endcase
    end
  end

  // Tick and sample counters; parked while idle so bit phase follows the start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
      samp_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      tick_cnt_r <= brd_eff_s - BRD_ONE;
      samp_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= brd_r - BRD_ONE;
      samp_cnt_r <= (samp_cnt_r == SMP_LAST) ? '0 : samp_cnt_r + CNT_W'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r - BRD_ONE;
    end
  end

  // Frame configuration latch, vote samples and payload/parity/stop capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_r   <= PAR_NONE;
      two_stop_r <= 1'b0;
      brd_r      <= BRD_ONE;
      samp_a_r   <= 1'b1;
      samp_b_r   <= 1'b1;
      bit_cnt_r  <= '0;
      data_r     <= '0;
      pbit_r     <= 1'b0;
      stop1_r    <= 1'b1;
    end else begin
      if (start_s) begin
        parity_r   <= parity_e'(parity_mode);
        two_stop_r <= two_stop;
        brd_r      <= brd_eff_s;
      end
      if (tick_s && (samp_cnt_r == SMP_A)) samp_a_r <= rx_sync_r;
      if (tick_s && (samp_cnt_r == SMP_B)) samp_b_r <= rx_sync_r;
      if (state_r == IDLE) begin
        bit_cnt_r <= '0;
      end else if (mid_s && (state_r == DATA)) begin
        data_r    <= {vote_s, data_r[DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (mid_s && (state_r == PARITY)) pbit_r  <= vote_s;
      if (mid_s && (state_r == STOP))   stop1_r <= vote_s;
    end
  end

  // Sticky overrun; a new drop in the same cycle wins over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            overrun_r <= 1'b0;
    else if (overflow_s) overrun_r <= 1'b1;
    else if (ovr_clr)    overrun_r <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_s),
    .wr_data  ({err_s, data_r}),
    .rd_en    (rd_en),
    .rd_data  (head_s),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow_s)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised bench for uart_rx_param: frames are built bit by bit on the line
// and the expected FIFO contents come from a queue-based model of the frame rules.
module tb_uart_rx_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_i, rx_en, two_stop, rd_en, ovr_clr;
  logic [15:0] brd;
  logic [1:0]  parity_mode;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic        empty, full, overrun, busy;
  logic [4:0]  level;

  int          n_vec = 0;
  int          n_err = 0;
  logic [10:0] mq[$];
  logic        model_ovr = 1'b0;

  logic [7:0]  r_d;
  logic [1:0]  r_pm;
  logic        r_ts, r_pf, r_s1, r_s2;
  logic [15:0] r_b;
  logic [7:0]  abort_byte;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(16), .BRD_W(16)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rx_en(rx_en), .brd(brd),
    .parity_mode(parity_mode), .two_stop(two_stop), .rd_en(rd_en),
    .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
    .level(level), .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame; glitch_bit inverts one clk of that frame bit, hold_bits keeps the line low afterwards
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                            input logic pflip, input logic s1, input logic s2,
                            input logic [15:0] b, input int glitch_bit, input int hold_bits);
    int   bc, ones, ones_tot;
    logic pen, pb, perr, frm, brk;
    logic bits[$];
    bc = 16 * ((b == 16'd0) ? 1 : int'(b));
    brd = b; parity_mode = pm; two_stop = ts;
    @(negedge clk);
    pen  = (pm == 2'd1) || (pm == 2'd2);
    ones = $countones(d);
    pb   = ((pm == 2'd2) ? ~ones[0] : ones[0]) ^ pflip;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pb);
    bits.push_back(s1);
    if (ts) bits.push_back(s2);
    foreach (bits[k]) begin
      for (int c = 0; c < bc; c++) begin
        rx_i = (k == glitch_bit && c == 9) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
    end
    ones_tot = ones + (pen ? int'(pb) : 0);
    perr = pen && ((pm == 2'd1) ? (ones_tot % 2 == 1) : (ones_tot % 2 == 0));
    frm  = !s1 || (ts && !s2);
    brk  = (d == 8'd0) && !(pen && pb) && !s1;
    if (mq.size() < 16) mq.push_back({brk, frm, perr, d});
    else                model_ovr = 1'b1;
    if (hold_bits > 0) begin
      rx_i = 1'b0;
      repeat (hold_bits * bc) @(negedge clk);
      check("hold_busy", busy, 1'b1);
      check("hold_level", level, mq.size());
    end
    rx_i = 1'b1;
    repeat (bc + 8) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [10:0] e;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      check({tag, "_data"}, rd_data, e[7:0]);
      check({tag, "_err"}, rd_err, e[10:8]);
    end else begin
      check({tag, "_empty"}, empty, 1'b1);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, "_level"}, level, mq.size());
  endtask

  initial begin
    rx_i = 1'b1; rx_en = 1'b1; brd = 16'd1; parity_mode = 2'd0; two_stop = 1'b0;
    rd_en = 1'b0; ovr_clr = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", rd_data, 8'h00);
    check("rst_err", rd_err, 3'b000);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 basic frame
    send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, -1, 0);
    check("t1_data", rd_data, 8'hA5);
    check("t1_err", rd_err, 3'b000);
    check("t1_level", level, 5'd1);
    pop_check("t1_pop");
    check("t1_empty", empty, 1'b1);

    // Even parity: wrong then right parity bit
    send_frame(8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, -1, 0);
    send_frame(8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, -1, 0);
    check("t2_bad_err", rd_err, 3'b001);
    pop_check("t2_pop_a");
    check("t2_ok_err", rd_err, 3'b000);
    pop_check("t2_pop_b");

    // Second stop low, then a break held for 20 bit-times
    send_frame(8'h3C, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, -1, 0);
    check("t3_stop2_err", rd_err, 3'b010);
    pop_check("t3_pop");
    send_frame(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, -1, 20);
    check("t3_brk_level", level, 5'd1);
    check("t3_brk_err", rd_err, 3'b110);
    check("t3_brk_busy", busy, 1'b0);
    pop_check("t3_brk_pop");

    // Overflow: 17 frames, no reads
    for (int i = 0; i < 17; i++)
      send_frame(8'(i), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, -1, 0);
    check("t4_full", full, 1'b1);
    check("t4_level", level, 5'd16);
    check("t4_overrun", overrun, 1'b1);
    check("t4_head", rd_data, 8'h00);
    ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0; model_ovr = 1'b0;
    check("t4_ovr_clr", overrun, 1'b0);
    for (int i = 0; i < 16; i++) pop_check("t4_drain");
    pop_check("t4_pop_empty");

    // Start-bit glitch rejection
    rx_i = 1'b0; repeat (5) @(negedge clk);
    rx_i = 1'b1; repeat (2) @(negedge clk);
    check("t5_glitch_busy", busy, 1'b1);
    repeat (13) @(negedge clk);
    check("t5_glitch_idle", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("t5_glitch_level", level, 5'd0);
    // One-clk glitch inside data bit 3 of 0x55 (frame bit 4)
    send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 4, 0);
    check("t5_vote_data", rd_data, 8'h55);
    pop_check("t5_vote_pop");

    // rx_en dropped during data bit 4
    abort_byte = 8'hC3; brd = 16'd1; parity_mode = 2'd0; two_stop = 1'b0;
    rx_i = 1'b0; repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin rx_i = abort_byte[i]; repeat (16) @(negedge clk); end
    rx_i = abort_byte[4]; repeat (8) @(negedge clk);
    check("t6_busy_pre", busy, 1'b1);
    rx_en = 1'b0; @(negedge clk);
    check("t6_busy_abort", busy, 1'b0);
    for (int i = 5; i < 8; i++) begin rx_i = abort_byte[i]; repeat (16) @(negedge clk); end
    rx_i = 1'b1; repeat (40) @(negedge clk);
    rx_en = 1'b1; repeat (20) @(negedge clk);
    check("t6_abort_level", level, 5'd0);

    // Asynchronous reset mid-frame with three entries held
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, -1, 0);
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, -1, 0);
    send_frame(8'h33, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, -1, 0);
    check("t6_pre_level", level, 5'd3);
    rx_i = 1'b0; repeat (20) @(negedge clk);
    rst = 1'b0; #1;
    check("t6_rst_data", rd_data, 8'h00);
    check("t6_rst_err", rd_err, 3'b000);
    check("t6_rst_empty", empty, 1'b1);
    check("t6_rst_full", full, 1'b0);
    check("t6_rst_level", level, 5'd0);
    check("t6_rst_ovr", overrun, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    mq.delete(); model_ovr = 1'b0;
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Randomised frames against the model
    for (int it = 0; it < 40; it++) begin
      r_d  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      r_pm = 2'($urandom);
      r_ts = 1'($urandom);
      r_pf = ($urandom_range(0, 3) == 0);
      r_s1 = ($urandom_range(0, 4) != 0);
      r_s2 = ($urandom_range(0, 4) != 0);
      r_b  = 16'($urandom_range(0, 2));
      send_frame(r_d, r_pm, r_ts, r_pf, r_s1, r_s2, r_b, -1, 0);
      check("rnd_level", level, mq.size());
      check("rnd_overrun", overrun, model_ovr);
      repeat ($urandom_range(0, 2)) pop_check("rnd_pop");
      if ($urandom_range(0, 7) == 0) begin
        ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0; model_ovr = 1'b0;
        check("rnd_ovr_clr", overrun, 1'b0);
      end
    end
    while (mq.size() > 0) pop_check("final_drain");
    check("final_empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
